// File: rtl/comparator_csr_bank_pkg.sv
// Shared constants for the comparator CSR bank: address map, EXC field layout and FSM states.
package comparator_csr_pkg;

  localparam logic [7:0] ADDR_EXC      = 8'h00;
  localparam logic [7:0] ADDR_SUCCESS  = 8'h01;
  localparam logic [7:0] ADDR_FAIL     = 8'h02;
  localparam logic [7:0] ADDR_MAXCOUNT = 8'h03;

  // Address bits [7:6] select a window; bits [5:0] index within it.
  localparam logic [1:0] WIN_REG   = 2'b00;
  localparam logic [1:0] WIN_START = 2'b01;
  localparam logic [1:0] WIN_END   = 2'b10;
  localparam logic [1:0] WIN_CORE  = 2'b11;

  localparam int EXC_NONEMPTY_BIT = 31;
  localparam int EXC_COUNT_LSB    = 16;
  localparam int EXC_TASK_LSB     = 4;
  localparam int EXC_COLL_BIT     = 0;
  localparam int EXC_POP_BIT      = 0;
  localparam int EXC_CLEAR_BIT    = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSR_WR,
    ST_CSR_RD,
    ST_HT_SET,
    ST_WAITREQ,
    ST_COMP_WR,
    ST_COMP_ACK
  } state_t;

endpackage

// File: rtl/comparator_csr_bank_if.sv
// Avalon-MM style CSR port of the comparator CSR bank.
interface comparator_csr_bank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] csr_address;
  logic              csr_read;
  logic              csr_write;
  logic [DATA_W-1:0] csr_writedata;
  logic [DATA_W-1:0] csr_readdata;
  logic              csr_waitrequest;

  modport master (
    output csr_address, csr_read, csr_write, csr_writedata,
    input  csr_readdata, csr_waitrequest
  );

  modport slave (
    input  csr_address, csr_read, csr_write, csr_writedata,
    output csr_readdata, csr_waitrequest
  );
endinterface

// File: rtl/comparator_csr_bank_event_fifo.sv
// Synchronous FIFO buffering comparator verdicts {task, collision} until software pops them.
module comparator_event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/comparator_csr_bank.sv
// CSR bank for the fingerprint comparator: pointer RAMs, core table, verdict bitmaps and event queue,
// all serialised through one access FSM.
//
// state      | meaning
// IDLE       | wait for CSR write, CSR read or comparator verdict (in that priority)
// CSR_WR     | apply the write to registers / RAMs / queue
// CSR_RD     | register the read data
// HT_SET     | hold set_head_tail until head_tail_ack
// WAITREQ    | drop csr_waitrequest for one cycle
// COMP_WR    | enqueue verdict and update bitmaps
// COMP_ACK   | pulse comp_status_ack
module comparator_csr_bank
  import comparator_csr_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int NUM_TASKS = 16,
  parameter int PTR_W     = 10,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int EVT_DEPTH = 4,
  localparam int TASK_W = $clog2(NUM_TASKS),
  localparam int CORE_W = $clog2(NUM_CORES),
  localparam int CNT_W  = $clog2(EVT_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  comparator_csr_bank_if.slave  csr,
  input  logic                  comp_status_write,
  input  logic [TASK_W-1:0]     comp_task,
  input  logic                  comp_collision_detected,
  output logic                  comp_status_ack,
  output logic                  set_head_tail,
  output logic [TASK_W-1:0]     head_tail_offset,
  output logic [PTR_W-1:0]      head_tail_data,
  input  logic                  head_tail_ack,
  input  logic [TASK_W-1:0]     comp_fprint_task_id,
  output logic [PTR_W-1:0]      start_pointer_ex,
  output logic [PTR_W-1:0]      end_pointer_ex,
  output logic [PTR_W-1:0]      start_pointer_comp,
  output logic [PTR_W-1:0]      end_pointer_comp,
  input  logic [3:0]            physical_core_id,
  input  logic [TASK_W-1:0]     fprint_task_id,
  output logic [CORE_W-1:0]     logical_core_id,
  output logic                  logical_core_valid,
  output logic                  csr_maxcount_write,
  output logic [DATA_W-1:0]     csr_maxcount_writedata,
  output logic                  irq
);
  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_readdata;
  logic [DATA_W-1:0]   r_success;
  logic [DATA_W-1:0]   r_fail;
  logic [TASK_W-1:0]   r_ht_offset;
  logic [PTR_W-1:0]    r_ht_data;
  logic [PTR_W-1:0]    r_start_mem [NUM_TASKS];
  logic [PTR_W-1:0]    r_end_mem   [NUM_TASKS];
  logic [NUM_TASKS-1:0] r_core_valid [NUM_CORES];
  logic [3:0]          r_core_phys  [NUM_CORES][NUM_TASKS];

  logic [7:0]          w_a8;
  logic [1:0]          w_win;
  logic [5:0]          w_idx;
  logic                w_hi_zero;
  logic [TASK_W-1:0]   w_task_idx;
  logic [CORE_W-1:0]   w_core_idx;
  logic [TASK_W-1:0]   w_cfg_task;
  logic                w_cfg_task_ok;
  logic                w_exc, w_succ, w_failr, w_maxc, w_start, w_end, w_core;
  logic                w_wr_en, w_push, w_pop, w_flush, w_waitreq;
  logic [DATA_W-1:0]   w_rd_data;
  logic [TASK_W:0]     w_fifo_head;
  logic [CNT_W-1:0]    w_fifo_count;
  logic                w_fifo_full, w_fifo_empty;

  assign w_a8       = csr.csr_address[7:0];
  assign w_win      = csr.csr_address[7:6];
  assign w_idx      = csr.csr_address[5:0];
  assign w_task_idx = w_idx[TASK_W-1:0];
  assign w_core_idx = w_idx[CORE_W-1:0];
  assign w_cfg_task = csr.csr_writedata[8 +: TASK_W];
  assign w_cfg_task_ok = int'(csr.csr_writedata[15:8]) < NUM_TASKS;

  generate
    if (ADDR_W > 8) begin : g_hi_addr
      assign w_hi_zero = ~|csr.csr_address[ADDR_W-1:8];
    end else begin : g_no_hi_addr
      assign w_hi_zero = 1'b1;
    end
  endgenerate

  assign w_exc   = w_hi_zero && (w_a8 == ADDR_EXC);
  assign w_succ  = w_hi_zero && (w_a8 == ADDR_SUCCESS);
  assign w_failr = w_hi_zero && (w_a8 == ADDR_FAIL);
  assign w_maxc  = w_hi_zero && (w_a8 == ADDR_MAXCOUNT);
  assign w_start = w_hi_zero && (w_win == WIN_START) && (int'(w_idx) < NUM_TASKS);
  assign w_end   = w_hi_zero && (w_win == WIN_END)   && (int'(w_idx) < NUM_TASKS);
  assign w_core  = w_hi_zero && (w_win == WIN_CORE)  && (int'(w_idx) < NUM_CORES);

  always_comb begin
    w_state_nxt     = r_state;
    w_waitreq       = 1'b1;
    comp_status_ack = 1'b0;
    set_head_tail   = 1'b0;
    w_wr_en         = 1'b0;
    w_push          = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (csr.csr_write)                          w_state_nxt = ST_CSR_WR;
        else if (csr.csr_read)                      w_state_nxt = ST_CSR_RD;
        else if (comp_status_write && !w_fifo_full) w_state_nxt = ST_COMP_WR;
      end
      ST_CSR_WR: begin
        w_wr_en     = reset_n;
        w_state_nxt = w_start ? ST_HT_SET : ST_WAITREQ;
      end
      ST_CSR_RD:   w_state_nxt = ST_WAITREQ;
      ST_HT_SET: begin
        set_head_tail = 1'b1;
        if (head_tail_ack) w_state_nxt = ST_WAITREQ;
      end
      ST_WAITREQ: begin
        w_waitreq   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      ST_COMP_WR: begin
        w_push      = reset_n;
        w_state_nxt = ST_COMP_ACK;
      end
      ST_COMP_ACK: begin
        comp_status_ack = 1'b1;
        w_state_nxt     = ST_IDLE;
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // A clear request takes precedence over a pop carried in the same write.
  assign w_flush = w_wr_en && w_exc && csr.csr_writedata[EXC_CLEAR_BIT];
  assign w_pop   = w_wr_en && w_exc && csr.csr_writedata[EXC_POP_BIT] && !csr.csr_writedata[EXC_CLEAR_BIT];

  assign csr_maxcount_write     = w_wr_en && w_maxc;
  assign csr_maxcount_writedata = csr_maxcount_write ? csr.csr_writedata : '0;

  // The core table is write-only; reads of that window return 0.
  always_comb begin
    w_rd_data = '0;
    if (w_exc && !w_fifo_empty) begin
      w_rd_data[EXC_NONEMPTY_BIT]             = 1'b1;
      w_rd_data[EXC_COUNT_LSB +: CNT_W]       = w_fifo_count;
      w_rd_data[EXC_TASK_LSB +: TASK_W]       = w_fifo_head[TASK_W:1];
      w_rd_data[EXC_COLL_BIT]                 = w_fifo_head[0];
    end else if (w_succ) begin
      w_rd_data = r_success;
    end else if (w_failr) begin
      w_rd_data = r_fail;
    end else if (w_start) begin
      w_rd_data[PTR_W-1:0] = r_start_mem[w_task_idx];
    end else if (w_end) begin
      w_rd_data[PTR_W-1:0] = r_end_mem[w_task_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_readdata  <= '0;
      r_success   <= '0;
      r_fail      <= '0;
      r_ht_offset <= '0;
      r_ht_data   <= '0;
      for (int l = 0; l < NUM_CORES; l++) r_core_valid[l] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CSR_RD) r_readdata <= w_rd_data;
      if (w_flush) begin
        r_success <= '0;
        r_fail    <= '0;
      end
      if (w_push) begin
        r_fail[comp_task]    <= comp_collision_detected;
        r_success[comp_task] <= ~comp_collision_detected;
      end
      if (w_wr_en && w_start) begin
        r_ht_offset <= w_task_idx;
        r_ht_data   <= csr.csr_writedata[PTR_W-1:0];
      end
      if (w_wr_en && w_core && w_cfg_task_ok) r_core_valid[w_core_idx][w_cfg_task] <= 1'b1;
    end
  end

  // Pointer RAMs and core physical ids carry no reset; read ports return the pre-write value.
  always_ff @(posedge clk) begin
    if (w_wr_en && w_start) r_start_mem[w_task_idx] <= csr.csr_writedata[PTR_W-1:0];
    if (w_wr_en && w_end)   r_end_mem[w_task_idx]   <= csr.csr_writedata[PTR_W-1:0];
    if (w_wr_en && w_core && w_cfg_task_ok) r_core_phys[w_core_idx][w_cfg_task] <= csr.csr_writedata[3:0];
    start_pointer_ex   <= r_start_mem[comp_fprint_task_id];
    end_pointer_ex     <= r_end_mem[comp_fprint_task_id];
    start_pointer_comp <= r_start_mem[comp_task];
    end_pointer_comp   <= r_end_mem[comp_task];
  end

  always_comb begin
    logical_core_id    = '0;
    logical_core_valid = 1'b0;
    for (int l = NUM_CORES - 1; l >= 0; l--) begin
      if (r_core_valid[l][fprint_task_id] && (r_core_phys[l][fprint_task_id] == physical_core_id)) begin
        logical_core_id    = CORE_W'(l);
        logical_core_valid = 1'b1;
      end
    end
  end

  comparator_event_fifo #(
    .WIDTH (TASK_W + 1),
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  ({comp_task, comp_collision_detected}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign csr.csr_readdata    = r_readdata;
  assign csr.csr_waitrequest = w_waitreq;
  assign head_tail_offset    = r_ht_offset;
  assign head_tail_data      = r_ht_data;
  assign irq                 = !w_fifo_empty;
endmodule

// File: tb/tb_comparator_csr_bank.sv
// Directed bench for comparator_csr_bank: CSR reads checked by a scoreboard monitor, side signals checked inline.
`timescale 1ns/1ps
module tb_comparator_csr_bank;
  localparam int NUM_CORES = 2;
  localparam int NUM_TASKS = 16;
  localparam int PTR_W     = 10;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 8;
  localparam int EVT_DEPTH = 4;
  localparam int TASK_W    = 4;
  localparam int CORE_W    = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  comparator_csr_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) csr ();

  logic              comp_status_write;
  logic [TASK_W-1:0] comp_task;
  logic              comp_collision_detected;
  logic              comp_status_ack;
  logic              set_head_tail;
  logic [TASK_W-1:0] head_tail_offset;
  logic [PTR_W-1:0]  head_tail_data;
  logic              head_tail_ack;
  logic [TASK_W-1:0] comp_fprint_task_id;
  logic [PTR_W-1:0]  start_pointer_ex, end_pointer_ex, start_pointer_comp, end_pointer_comp;
  logic [3:0]        physical_core_id;
  logic [TASK_W-1:0] fprint_task_id;
  logic [CORE_W-1:0] logical_core_id;
  logic              logical_core_valid;
  logic              csr_maxcount_write;
  logic [DATA_W-1:0] csr_maxcount_writedata;
  logic              irq;

  comparator_csr_bank #(
    .NUM_CORES(NUM_CORES), .NUM_TASKS(NUM_TASKS), .PTR_W(PTR_W),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .EVT_DEPTH(EVT_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .csr(csr),
    .comp_status_write(comp_status_write), .comp_task(comp_task),
    .comp_collision_detected(comp_collision_detected), .comp_status_ack(comp_status_ack),
    .set_head_tail(set_head_tail), .head_tail_offset(head_tail_offset),
    .head_tail_data(head_tail_data), .head_tail_ack(head_tail_ack),
    .comp_fprint_task_id(comp_fprint_task_id),
    .start_pointer_ex(start_pointer_ex), .end_pointer_ex(end_pointer_ex),
    .start_pointer_comp(start_pointer_comp), .end_pointer_comp(end_pointer_comp),
    .physical_core_id(physical_core_id), .fprint_task_id(fprint_task_id),
    .logical_core_id(logical_core_id), .logical_core_valid(logical_core_valid),
    .csr_maxcount_write(csr_maxcount_write), .csr_maxcount_writedata(csr_maxcount_writedata),
    .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  bit          rd_active = 1'b0;

  int          acks = 0;
  int          mc_pulses = 0;
  logic [31:0] mc_data = '0;

  bit          ht_auto = 1'b1;
  int          ht_cnt = 0;
  int          ht_len = 0;
  logic [31:0] ht_off = '0;
  logic [31:0] ht_dat = '0;

  logic [TASK_W-1:0] vq_task[$];
  logic              vq_coll[$];
  int                vd_lat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor plus event counters for ack / maxcount strobes.
  initial begin
    string       n;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (comp_status_ack) acks++;
      if (csr_maxcount_write) begin
        mc_pulses++;
        mc_data = csr_maxcount_writedata;
      end
      if (rd_active && !csr.csr_waitrequest) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got 0x%0h with no expected value queued", csr.csr_readdata);
        end else begin
          n = nm_q.pop_front();
          e = exp_q.pop_front();
          check(n, csr.csr_readdata, e);
        end
      end
    end
  end

  // Head/tail responder: acks on the 3rd observed cycle of set_head_tail when enabled.
  initial begin
    head_tail_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (set_head_tail) begin
        ht_cnt++;
        ht_off = 32'(head_tail_offset);
        ht_dat = 32'(head_tail_data);
        head_tail_ack = ht_auto && (ht_cnt == 3);
      end else begin
        if (ht_cnt != 0) ht_len = ht_cnt;
        ht_cnt = 0;
        head_tail_ack = 1'b0;
      end
    end
  end

  // Comparator model: issues queued verdicts one at a time, holding each until acked.
  initial begin
    int waited;
    comp_status_write       = 1'b0;
    comp_task               = '0;
    comp_collision_detected = 1'b0;
    forever begin
      @(negedge clk);
      if (vq_task.size() != 0) begin
        comp_task               = vq_task.pop_front();
        comp_collision_detected = vq_coll.pop_front();
        comp_status_write       = 1'b1;
        waited = 0;
        do begin
          @(negedge clk);
          waited++;
        end while (!comp_status_ack && waited < 300);
        if (!comp_status_ack) begin
          total++;
          bad++;
          $display("FAIL verdict_timeout task %0d: ack 0 after %0d cycles, required 1", comp_task, waited);
        end
        vd_lat_q.push_back(waited);
        comp_status_write = 1'b0;
      end
    end
  end

  task automatic csr_wr(input logic [7:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    csr.csr_address   = a;
    csr.csr_writedata = d;
    csr.csr_write     = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (csr.csr_waitrequest && lat < 60);
    if (csr.csr_waitrequest) begin
      total++;
      bad++;
      $display("FAIL wr_timeout addr 0x%0h: waitrequest 1 after %0d cycles, required 0", a, lat);
    end
    #1 csr.csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [7:0] a, input logic [31:0] exp, input string name, output int lat);
    @(negedge clk);
    exp_q.push_back(exp);
    nm_q.push_back(name);
    csr.csr_address = a;
    csr.csr_read    = 1'b1;
    rd_active       = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (csr.csr_waitrequest && lat < 60);
    if (csr.csr_waitrequest) begin
      total++;
      bad++;
      $display("FAIL rd_timeout %s: waitrequest 1 after %0d cycles, required 0", name, lat);
      void'(exp_q.pop_front());
      void'(nm_q.pop_front());
    end
    #1;
    rd_active    = 1'b0;
    csr.csr_read = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_waitreq"}, 32'(csr.csr_waitrequest), 32'd1);
    check({tag, "_irq"},     32'(irq), 32'd0);
    check({tag, "_ack"},     32'(comp_status_ack), 32'd0);
    check({tag, "_sht"},     32'(set_head_tail), 32'd0);
    check({tag, "_mcw"},     32'(csr_maxcount_write), 32'd0);
    check({tag, "_rdata"},   csr.csr_readdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w;
    csr.csr_address   = '0;
    csr.csr_read      = 1'b0;
    csr.csr_write     = 1'b0;
    csr.csr_writedata = '0;
    comp_fprint_task_id = '0;
    physical_core_id    = '0;
    fprint_task_id      = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Start pointer write with head/tail handshake acked after 3 cycles.
    csr_wr(8'h45, 32'h0A5, lat);
    check("ht_wr_latency", 32'(lat), 32'd5);
    check("ht_len", 32'(ht_len), 32'd3);
    check("ht_offset", ht_off, 32'd5);
    check("ht_data", ht_dat, 32'h0A5);
    comp_fprint_task_id = 4'd5;
    @(negedge clk);
    check("start_ptr_ex", 32'(start_pointer_ex), 32'h0A5);

    csr_wr(8'h8C, 32'h2AB, lat);
    check("wr_latency", 32'(lat), 32'd2);
    comp_fprint_task_id = 4'd12;
    @(negedge clk);
    check("end_ptr_ex", 32'(end_pointer_ex), 32'h2AB);

    csr_rd(8'h45, 32'h0A5, "rd_start5", lat);
    check("rd_latency", 32'(lat), 32'd2);
    csr_rd(8'h10, 32'h0, "rd_unmapped", lat);
    csr_rd(8'h50, 32'h0, "rd_task_out_of_range", lat);

    csr_wr(8'h03, 32'h1234, lat);
    check("mc_pulses", 32'(mc_pulses), 32'd1);
    check("mc_data", mc_data, 32'h1234);
    check("irq_idle", 32'(irq), 32'd0);

    // Five verdicts into a 4-deep queue: the 5th must stall.
    vq_task.push_back(4'd3);  vq_coll.push_back(1'b0);
    vq_task.push_back(4'd7);  vq_coll.push_back(1'b1);
    vq_task.push_back(4'd2);  vq_coll.push_back(1'b0);
    vq_task.push_back(4'd9);  vq_coll.push_back(1'b1);
    vq_task.push_back(4'd12); vq_coll.push_back(1'b0);
    repeat (30) @(negedge clk);
    check("acks_when_full", 32'(acks), 32'd4);
    check("stall_held", 32'(comp_status_write), 32'd1);
    check("irq_nonempty", 32'(irq), 32'd1);
    w = (vd_lat_q.size() != 0) ? vd_lat_q[0] : -1;
    check("verdict_latency", 32'(w), 32'd2);
    csr_rd(8'h00, 32'h8004_0030, "exc_full", lat);

    csr_wr(8'h00, 32'h1, lat);
    repeat (10) @(negedge clk);
    check("acks_after_pop", 32'(acks), 32'd5);
    check("end_ptr_comp", 32'(end_pointer_comp), 32'h2AB);
    csr_rd(8'h00, 32'h8004_0071, "exc_after_pop", lat);
    csr_wr(8'h00, 32'h1, lat);
    csr_rd(8'h00, 32'h8003_0020, "exc_pop2", lat);
    csr_wr(8'h00, 32'h1, lat);
    csr_rd(8'h00, 32'h8002_0091, "exc_pop3", lat);
    csr_wr(8'h00, 32'h1, lat);
    csr_rd(8'h00, 32'h8001_00C0, "exc_pop4", lat);
    csr_wr(8'h00, 32'h1, lat);
    check("irq_after_last_pop", 32'(irq), 32'd0);
    csr_rd(8'h00, 32'h0, "exc_empty", lat);
    csr_wr(8'h00, 32'h1, lat);
    csr_rd(8'h00, 32'h0, "exc_pop_when_empty", lat);
    csr_rd(8'h01, 32'h0000_100C, "success_bitmap", lat);
    csr_rd(8'h02, 32'h0000_0280, "fail_bitmap", lat);

    // Core table lookup: lowest matching slot wins.
    csr_wr(8'hC1, 32'h0502, lat);
    fprint_task_id = 4'd5; physical_core_id = 4'd2; #1;
    check("lookup_id_s1", 32'(logical_core_id), 32'd1);
    check("lookup_valid_s1", 32'(logical_core_valid), 32'd1);
    physical_core_id = 4'd3; #1;
    check("lookup_miss_valid", 32'(logical_core_valid), 32'd0);
    check("lookup_miss_id", 32'(logical_core_id), 32'd0);
    csr_wr(8'hC0, 32'h0507, lat);
    physical_core_id = 4'd7; #1;
    check("lookup_id_s0", 32'(logical_core_id), 32'd0);
    check("lookup_valid_s0", 32'(logical_core_valid), 32'd1);
    physical_core_id = 4'd2; #1;
    check("lookup_id_s1_again", 32'(logical_core_id), 32'd1);
    fprint_task_id = 4'd4; #1;
    check("lookup_other_task", 32'(logical_core_valid), 32'd0);

    // Clear bitmaps and flush a non-empty queue.
    vq_task.push_back(4'd5); vq_coll.push_back(1'b1);
    vq_task.push_back(4'd6); vq_coll.push_back(1'b0);
    repeat (15) @(negedge clk);
    check("acks_before_flush", 32'(acks), 32'd7);
    check("irq_before_flush", 32'(irq), 32'd1);
    csr_wr(8'h00, 32'h2, lat);
    check("irq_after_flush", 32'(irq), 32'd0);
    csr_rd(8'h00, 32'h0, "exc_flushed", lat);
    csr_rd(8'h01, 32'h0, "success_cleared", lat);
    csr_rd(8'h02, 32'h0, "fail_cleared", lat);

    // Reset while a start-pointer write is stuck in the head/tail handshake.
    csr_rd(8'h45, 32'h0A5, "rd_before_reset", lat);
    ht_auto = 1'b0;
    @(negedge clk);
    csr.csr_address   = 8'h47;
    csr.csr_writedata = 32'h55;
    csr.csr_write     = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!set_head_tail && w < 20);
    check("ht_stall_seen", 32'(set_head_tail), 32'd1);
    reset_n       = 1'b0;
    csr.csr_write = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    ht_auto = 1'b1;
    @(negedge clk);
    csr_rd(8'h00, 32'h0, "exc_after_reset", lat);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
